// File: rtl/grf_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: tracks in-flight GRF writes in E/M/W,
// raises the D-stage stall, picks forwarding sources and times the MDU busy window.
module grf_hazard_ctrl #(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_valid,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_rs_tuse,
  input  logic [1:0] d_rt_tuse,
  input  logic [4:0] d_dst,
  input  logic [1:0] d_tnew,
  input  logic       d_md_use,
  input  logic       d_md_start,
  input  logic       d_md_div,
  output logic       stall,
  output logic [1:0] d_rs_fwd,
  output logic [1:0] d_rt_fwd,
  output logic [1:0] e_rs_fwd,
  output logic [1:0] e_rt_fwd,
  output logic       mdu_busy
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned TNEW_W = 2;
  localparam int unsigned TUSE_W = 2;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned CNT_W  = 4;

  localparam logic [SEL_W-1:0]  SEL_GRF   = 2'd0;
  localparam logic [SEL_W-1:0]  SEL_E     = 2'd1;
  localparam logic [SEL_W-1:0]  SEL_M     = 2'd2;
  localparam logic [SEL_W-1:0]  SEL_W_STG = 2'd3;
  localparam logic [TUSE_W-1:0] TUSE_NONE = 2'd3;

  typedef struct packed {
    logic [REG_W-1:0]  dst;
    logic [TNEW_W-1:0] tnew;
  } wr_rec_t;

  typedef struct packed {
    wr_rec_t          wr;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             md_start;
    logic             md_div;
  } e_rec_t;

  e_rec_t           e_q;
  e_rec_t           e_d;
  wr_rec_t          m_q;
  wr_rec_t          w_q;
  logic [CNT_W-1:0] cnt_q;
  logic             stall_c;
  logic             busy_c;

  function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - TNEW_W'(1);
  endfunction

  function automatic logic src_stall(input logic [REG_W-1:0]  s,
                                     input logic [TUSE_W-1:0] tuse,
                                     input wr_rec_t           e,
                                     input wr_rec_t           m);
    if (s == '0 || tuse == TUSE_NONE) return 1'b0;
    return ((e.dst == s) && (e.tnew > tuse)) || ((m.dst == s) && (m.tnew > tuse));
  endfunction

  // The youngest stage writing s decides; if its value is not ready yet, select
  // nothing and rely on the stall rather than forwarding an older stale value.
  function automatic logic [SEL_W-1:0] d_sel(input logic [REG_W-1:0] s,
                                             input wr_rec_t          e,
                                             input wr_rec_t          m,
                                             input wr_rec_t          w);
    if (s == '0)    return SEL_GRF;
    if (e.dst == s) return (e.tnew == '0) ? SEL_E : SEL_GRF;
    if (m.dst == s) return (m.tnew == '0) ? SEL_M : SEL_GRF;
    if (w.dst == s) return (w.tnew == '0) ? SEL_W_STG : SEL_GRF;
    return SEL_GRF;
  endfunction

  function automatic logic [SEL_W-1:0] e_sel(input logic [REG_W-1:0] s,
                                             input wr_rec_t          m,
                                             input wr_rec_t          w);
    if (s == '0)    return SEL_GRF;
    if (m.dst == s) return (m.tnew == '0) ? SEL_M : SEL_GRF;
    if (w.dst == s) return (w.tnew == '0) ? SEL_W_STG : SEL_GRF;
    return SEL_GRF;
  endfunction

  assign busy_c = (cnt_q != '0) || e_q.md_start;

  // D-stage stall: operand not ready in time, or HI/LO access while the MDU runs.
  always_comb begin
    stall_c = 1'b0;
    if (d_valid) begin
      stall_c = src_stall(d_rs, d_rs_tuse, e_q.wr, m_q)
             || src_stall(d_rt, d_rt_tuse, e_q.wr, m_q)
             || (d_md_use && busy_c);
    end
  end

  // Record entering E: the D instruction, or a bubble when stalled or invalid.
  always_comb begin
    e_d = '0;
    if (d_valid && !stall_c) begin
      e_d.wr.dst   = d_dst;
      e_d.wr.tnew  = d_tnew;
      e_d.rs       = d_rs;
      e_d.rt       = d_rt;
      e_d.md_start = d_md_start;
      e_d.md_div   = d_md_div;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q      <= e_d;
      m_q.dst  <= e_q.wr.dst;
      m_q.tnew <= tnew_dec(e_q.wr.tnew);
      w_q.dst  <= m_q.dst;
      w_q.tnew <= tnew_dec(m_q.tnew);
    end
  end

  // MDU window: reloads whenever a start leaves E, even while D is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (e_q.md_start) begin
      cnt_q <= e_q.md_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    stall    = stall_c;
    mdu_busy = busy_c;
    d_rs_fwd = d_sel(d_rs, e_q.wr, m_q, w_q);
    d_rt_fwd = d_sel(d_rt, e_q.wr, m_q, w_q);
    e_rs_fwd = e_sel(e_q.rs, m_q, w_q);
    e_rt_fwd = e_sel(e_q.rt, m_q, w_q);
  end

endmodule

// File: tb/tb_grf_hazard_ctrl.sv
// Bench for grf_hazard_ctrl: directed hazard scenarios with literal expectations,
// then random traffic checked every cycle against an age-based pipeline model.
module tb_grf_hazard_ctrl;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic       clk;
  logic       rst;
  logic       d_valid;
  logic [4:0] d_rs, d_rt, d_dst;
  logic [1:0] d_rs_tuse, d_rt_tuse, d_tnew;
  logic       d_md_use, d_md_start, d_md_div;
  logic       stall, mdu_busy;
  logic [1:0] d_rs_fwd, d_rt_fwd, e_rs_fwd, e_rt_fwd;

  grf_hazard_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst), .d_valid(d_valid),
    .d_rs(d_rs), .d_rt(d_rt), .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
    .d_dst(d_dst), .d_tnew(d_tnew), .d_md_use(d_md_use),
    .d_md_start(d_md_start), .d_md_div(d_md_div),
    .stall(stall), .d_rs_fwd(d_rs_fwd), .d_rt_fwd(d_rt_fwd),
    .e_rs_fwd(e_rs_fwd), .e_rt_fwd(e_rt_fwd), .mdu_busy(mdu_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the last three instructions to enter E, newest first (index = age in stages).
  typedef struct {
    logic [4:0] dst;
    int         tnew;
    logic [4:0] rs;
    logic [4:0] rt;
    bit         md_start;
    bit         md_div;
  } ins_t;

  ins_t hist [3];
  int   now        = 0;
  int   mdu_until  = -1;
  int   n_cmp      = 0;
  int   n_err      = 0;
  bit   chk_en     = 1'b0;

  function automatic ins_t bubble_ins();
    ins_t b;
    b.dst = 5'd0; b.tnew = 0; b.rs = 5'd0; b.rt = 5'd0; b.md_start = 1'b0; b.md_div = 1'b0;
    return b;
  endfunction

  // Cycles still needed before the result of the instruction k stages past E exists.
  function automatic int rem(input int k);
    int r;
    r = hist[k].tnew - k;
    return (r < 0) ? 0 : r;
  endfunction

  function automatic bit exp_busy();
    return hist[0].md_start || (now <= mdu_until);
  endfunction

  function automatic bit src_hazard(input logic [4:0] s, input int tuse);
    if (s == 5'd0 || tuse == 3) return 1'b0;
    for (int k = 0; k < 2; k++)
      if (hist[k].dst == s && rem(k) > tuse) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_stall();
    if (!d_valid) return 1'b0;
    return src_hazard(d_rs, int'(d_rs_tuse)) || src_hazard(d_rt, int'(d_rt_tuse))
        || (d_md_use && exp_busy());
  endfunction

  function automatic int exp_fwd(input logic [4:0] s, input int first_k);
    if (s == 5'd0) return 0;
    for (int k = first_k; k < 3; k++)
      if (hist[k].dst == s) return (rem(k) == 0) ? k + 1 : 0;
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, now, act, exp);
    end
  endtask

  task automatic model_update();
    bit   st;
    ins_t n;
    if (rst) begin
      for (int k = 0; k < 3; k++) hist[k] = bubble_ins();
      mdu_until = -1;
      chk_en    = 1'b1;
    end else begin
      st = exp_stall();
      if (hist[0].md_start) mdu_until = now + (hist[0].md_div ? DIV_LAT : MUL_LAT);
      n = bubble_ins();
      if (d_valid && !st) begin
        n.dst = d_dst; n.tnew = int'(d_tnew); n.rs = d_rs; n.rt = d_rt;
        n.md_start = d_md_start; n.md_div = d_md_div;
      end
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = n;
    end
    now++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_d(input bit v, input int rs, input int rt, input int rs_tu, input int rt_tu,
                       input int dst, input int tn, input bit mu, input bit ms, input bit md);
    d_valid = v; d_rs = 5'(rs); d_rt = 5'(rt); d_rs_tuse = 2'(rs_tu); d_rt_tuse = 2'(rt_tu);
    d_dst = 5'(dst); d_tnew = 2'(tn); d_md_use = mu; d_md_start = ms; d_md_div = md;
  endtask

  task automatic bubble();
    set_d(1'b0, 0, 0, 3, 3, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall",    32'(stall),    32'(exp_stall()));
      chk("mdu_busy", 32'(mdu_busy), 32'(exp_busy()));
      chk("d_rs_fwd", 32'(d_rs_fwd), 32'(exp_fwd(d_rs, 0)));
      chk("d_rt_fwd", 32'(d_rt_fwd), 32'(exp_fwd(d_rt, 0)));
      chk("e_rs_fwd", 32'(e_rs_fwd), 32'(exp_fwd(hist[0].rs, 1)));
      chk("e_rt_fwd", 32'(e_rt_fwd), 32'(exp_fwd(hist[0].rt, 1)));
    end
  end

  task automatic count_md_stall(input string name, input int expect_n);
    int n;
    n = 0;
    while (stall === 1'b1 && n < 30) begin
      n++;
      tick();
      #3;
    end
    chk(name, 32'(n), 32'(expect_n));
  endtask

  initial begin
    for (int k = 0; k < 3; k++) hist[k] = bubble_ins();
    rst = 1'b1;
    bubble();
    tick();
    tick();
    rst = 1'b0;

    // Reset in the middle of a divide
    set_d(1'b1, 1, 2, 1, 1, 0, 0, 1'b1, 1'b1, 1'b1);
    tick();
    bubble();
    tick(); tick(); tick();
    #3;
    chk("t1_busy_mid_div", 32'(mdu_busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_d(1'b1, 4, 5, 0, 0, 6, 1, 1'b1, 1'b0, 1'b0);
    #3;
    chk("t1_busy_after_rst",  32'(mdu_busy), 32'd0);
    chk("t1_stall_after_rst", 32'(stall),    32'd0);
    chk("t1_fwd_after_rst",   32'({d_rs_fwd, d_rt_fwd, e_rs_fwd, e_rt_fwd}), 32'd0);
    tick();

    // ALU result feeding a branch
    set_d(1'b1, 1, 2, 1, 1, 3, 1, 1'b0, 1'b0, 1'b0);
    tick();
    set_d(1'b1, 3, 4, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    #3;
    chk("t2_stall", 32'(stall), 32'd1);
    tick();
    #3;
    chk("t2_stall_released", 32'(stall),    32'd0);
    chk("t2_d_rs_fwd_m",     32'(d_rs_fwd), 32'd2);
    tick();

    // Load-use
    set_d(1'b1, 6, 0, 1, 3, 5, 2, 1'b0, 1'b0, 1'b0);
    tick();
    set_d(1'b1, 5, 6, 1, 1, 8, 1, 1'b0, 1'b0, 1'b0);
    #3;
    chk("t3_stall", 32'(stall), 32'd1);
    tick();
    #3;
    chk("t3_stall_released", 32'(stall), 32'd0);
    tick();
    bubble();
    #3;
    chk("t3_e_rs_fwd_w", 32'(e_rs_fwd), 32'd3);
    chk("t3_e_rt_fwd",   32'(e_rt_fwd), 32'd0);

    // Writes to $0 never create hazards
    set_d(1'b1, 1, 0, 1, 3, 0, 2, 1'b0, 1'b0, 1'b0);
    tick();
    set_d(1'b1, 0, 0, 0, 0, 9, 1, 1'b0, 1'b0, 1'b0);
    #3;
    chk("t4_stall", 32'(stall), 32'd0);
    chk("t4_d_fwd", 32'({d_rs_fwd, d_rt_fwd}), 32'd0);
    tick();
    bubble();
    #3;
    chk("t4_e_fwd", 32'({e_rs_fwd, e_rt_fwd}), 32'd0);

    // Forwarding priority and blocking by a younger unfinished write
    set_d(1'b1, 0, 0, 3, 3, 7, 0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    set_d(1'b1, 7, 0, 0, 3, 0, 0, 1'b0, 1'b0, 1'b0);
    #3;
    chk("t5_stall_none", 32'(stall),    32'd0);
    chk("t5_d_rs_fwd_e", 32'(d_rs_fwd), 32'd1);
    set_d(1'b1, 0, 0, 3, 3, 7, 1, 1'b0, 1'b0, 1'b0);
    tick();
    set_d(1'b1, 7, 0, 0, 3, 0, 0, 1'b0, 1'b0, 1'b0);
    #3;
    chk("t5_stall_blocked", 32'(stall),    32'd1);
    chk("t5_fwd_blocked",   32'(d_rs_fwd), 32'd0);
    tick();
    #3;
    chk("t5_stall_released", 32'(stall),    32'd0);
    chk("t5_d_rs_fwd_m",     32'(d_rs_fwd), 32'd2);
    tick();
    bubble();
    tick(); tick();

    // MDU window: divide, then multiply
    set_d(1'b1, 1, 2, 1, 1, 0, 0, 1'b1, 1'b1, 1'b1);
    tick();
    set_d(1'b1, 0, 0, 3, 3, 9, 1, 1'b1, 1'b0, 1'b0);
    #3;
    count_md_stall("t6_div_stall_cycles", DIV_LAT + 1);
    tick();
    set_d(1'b1, 9, 0, 0, 3, 0, 0, 1'b0, 1'b0, 1'b0);
    #3;
    chk("t6_mfhi_in_e", 32'(stall), 32'd1);
    tick();
    bubble();
    tick(); tick();
    set_d(1'b1, 1, 2, 1, 1, 0, 0, 1'b1, 1'b1, 1'b0);
    tick();
    set_d(1'b1, 0, 0, 3, 3, 10, 1, 1'b1, 1'b0, 1'b0);
    #3;
    count_md_stall("t6_mult_stall_cycles", MUL_LAT + 1);
    tick();
    bubble();
    tick();

    // Random traffic on a small register set so hazards are frequent
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst        = ($urandom_range(0, 63) == 0);
      d_valid    = ($urandom_range(0, 9) != 0);
      d_rs       = 5'($urandom_range(0, 7));
      d_rt       = 5'($urandom_range(0, 7));
      d_rs_tuse  = 2'($urandom_range(0, 3));
      d_rt_tuse  = 2'($urandom_range(0, 3));
      d_dst      = 5'($urandom_range(0, 7));
      d_tnew     = 2'($urandom_range(0, 2));
      d_md_start = ($urandom_range(0, 7) == 0);
      d_md_div   = ($urandom_range(0, 1) == 1);
      d_md_use   = d_md_start || ($urandom_range(0, 5) == 0);
    end
    rst = 1'b0;
    bubble();
    tick();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/grf_hazard_ctrl.md
Name: grf_hazard_ctrl

Overview:
- Hazard controller for the 5-stage pipeline around the register file.
- Keeps a scoreboard of in-flight register writes for E, M and W: destination and Tnew.
- Drives the D-stage stall, plus forwarding selects for D-stage and E-stage operands.
- Tracks the multiply/divide unit's busy window so that HI/LO users in D stall until the result is ready.

Parameters:
- MUL_LAT, 5, cycles the MDU is busy after a mult/multu leaves E
- DIV_LAT, 10, cycles the MDU is busy after a div/divu leaves E

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- d_valid  in  1  D holds a real instruction (0 = treat as bubble)
- d_rs  in  5  D source register rs
- d_rt  in  5  D source register rt
- d_rs_tuse  in  2  cycles until rs is needed (0=D, 1=E, 2=M, 3=unused)
- d_rt_tuse  in  2  same encoding for rt
- d_dst  in  5  D destination register (0 = no write)
- d_tnew  in  2  cycles after E entry until the result exists (0/1/2)
- d_md_use  in  1  D instruction reads or writes HI/LO or starts the MDU
- d_md_start  in  1  D instruction is mult/multu/div/divu
- d_md_div  in  1  with d_md_start: the instruction is a divide
- stall  out  1  freeze PC and the F/D register; inject a bubble into E
- d_rs_fwd  out  2  D rs source: 0 GRF, 1 E, 2 M, 3 W
- d_rt_fwd  out  2  D rt source, same encoding
- e_rs_fwd  out  2  E rs source: 0 register value latched in E, 2 M, 3 W
- e_rt_fwd  out  2  E rt source, same encoding
- mdu_busy  out  1  MDU result not yet available

Behaviour:
- Stage records:
  - Each of E, M and W holds {dst[4:0], tnew[1:0]}.
  - E additionally holds {rs, rt, md_start, md_div}.
  - A bubble is all-zero.
- Record update, every posedge clk when rst=0:
  - W <= M with tnew = sat0(M.tnew-1).
  - M <= E with tnew = sat0(E.tnew-1).
  - E <= D fields if (d_valid && !stall), otherwise bubble.
  - E, M and W always advance; only D/F freeze.
- MDU counter:
  - cnt is 4 bits wide, sized to hold DIV_LAT.
  - On an edge with E.md_start=1, cnt <= (E.md_div ? DIV_LAT : MUL_LAT).
  - Otherwise, if cnt != 0, cnt <= cnt-1.
  - mdu_busy = (cnt != 0) || E.md_start.
- Stall, combinational from the records and D inputs:
  - Per source s in {rs, rt}, with tuse != 3 and s != 0:
    - stall if (E.dst == s && E.tnew > tuse), or
    - stall if (M.dst == s && M.tnew > tuse).
  - W.tnew is always 0 and W never stalls.
  - Also stall if d_md_use && mdu_busy.
  - stall is forced to 0 when d_valid=0.
- D forwarding:
  - For a source s != 0, the select is the first match among E (dst==s, tnew==0), M (tnew==0), W.
  - Otherwise the select is 0.
  - W forwarding is required because GRF writes land only at the clock edge.
  - $0 never forwards.
- E forwarding:
  - For E.rs / E.rt != 0, the select is the first match among M (dst match, tnew==0), W.
  - Otherwise the select is 0.
- Simultaneous events:
  - Stall and an MDU start in E in the same cycle: the counter still loads.
  - A younger match with nonzero tnew blocks an older stage's forward, i.e. stall, never stale forwarding.
- Reset:
  - Clears all records and cnt on the next posedge, including when asserted mid-stall or mid-divide.
  - Following that edge, all outputs read 0.

Test Plan:
1. Reset mid-divide: rst=1 during DIV busy -> next cycle mdu_busy=0, stall=0, all fwd=0.
2. ALU-to-branch: D = addu $3 (tnew=1) followed by beq on $3 (tuse=0).
   - -> stall=1 for exactly 1 cycle.
   - -> then d_rs_fwd=2 (M).
3. Load-use: lw $5 (tnew=2) followed by addu reading $5 (tuse=1).
   - -> stall=1 for 1 cycle.
   - -> then e_rs_fwd=3 (W) once addu is in E.
4. Write-to-$0: instruction with dst=0 followed by one reading $0 -> stall=0, all fwd=0.
5. Priority: E and M both have dst=$7 with tnew=0 -> d_rs_fwd=1 (E).
   - E.dst=$7 with tnew=1 and M.dst=$7 with tnew=0, reader tuse=0 -> stall=1.
6. MDU window: div in E, then mfhi in D.
   - -> stall held for 11 cycles: the E cycle plus DIV_LAT.
   - -> mfhi then enters E.
   - Repeat with mult -> 6 cycles.
